imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Writer side of instruction memory: receives a program image as a byte stream
//   (e.g. from the UART receiver), assembles little-endian 32-bit words and writes
//   them into the instruction RAM write port at consecutive word addresses.
//   Holds the CPU in reset while loading; releases it when the image is complete.
// PARAMETERS
//   DEPTH   64  instruction RAM size in words; maximum accepted image length
//   LEN_W   16  width of the image word-count header (fixed LE, 2 bytes)
// PORTS
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high reset
//   start      in   1   pulse: begin a new load (honoured in IDLE, DONE, ERR only)
//   rx_valid   in   1   rx_data holds a byte
//   rx_data    in   8   incoming byte
//   rx_ready   out  1   loader accepts a byte this cycle
//   mem_we     out  1   instruction RAM write enable (one-cycle pulse per word)
//   mem_wa     out  32  byte address of word being written; bits[1:0] always 0
//   mem_wd     out  32  assembled instruction word
//   busy       out  1   load in progress (LEN0..WRITE)
//   done       out  1   image fully written (sticky until start/reset)
//   err        out  1   header length > DEPTH (sticky until start/reset)
//   cpu_reset  out  1   CPU reset; high in every state except DONE
// BEHAVIOUR
//   Reset: state=IDLE; rx_ready=0, mem_we=0, mem_wa=0, mem_wd=0, busy=0, done=0,
//     err=0, cpu_reset=1. Reset in any state (mid-word included) aborts; partial
//     word discarded, RAM contents already written left as is.
//   Byte accepted on a cycle with rx_valid && rx_ready; rx_ready depends only on
//     state (no combinational path from rx_valid).
//   Stream format: len[7:0], len[15:8], then len*4 bytes, each word LSB first.
//   States / transitions:
//     IDLE : rx_ready=0. start -> LEN0 (clear done/err, mem_wa=0, byte_cnt=0).
//     LEN0 : rx_ready=1. accept -> len[7:0], LEN1.
//     LEN1 : rx_ready=1. accept -> len[15:8]; next state decided on that byte:
//            len==0 -> DONE; len>DEPTH -> ERR; else DATA.
//     DATA : rx_ready=1. accept -> byte into mem_wd[8*byte_cnt +: 8], byte_cnt++.
//            On 4th byte (byte_cnt==3) -> WRITE, byte_cnt=0.
//     WRITE: rx_ready=0, mem_we=1 for exactly this cycle with stable wa/wd.
//            Next cycle mem_wa+=4, remaining--; remaining==0 -> DONE else DATA.
//     DONE : done=1, cpu_reset=0, rx_ready=0. start -> LEN0.
//     ERR  : err=1, cpu_reset=1, rx_ready=0, no writes. start -> LEN0.
//   Latency: mem_we asserts the cycle after the 4th byte of a word is accepted;
//     done and cpu_reset=0 the cycle after the last WRITE cycle.
//   Throughput: one word per 5 cycles max (4 accepts + WRITE); rx_valid gaps
//     stall DATA indefinitely with no timeout.
//   start while busy: ignored. start and rx_valid same cycle in IDLE: byte
//     not accepted (rx_ready=0 in IDLE).
//   Words written = len exactly; mem_wa never exceeds (DEPTH-1)*4.
//   Bytes arriving in IDLE/DONE/ERR are not accepted (upstream back-pressured).
// TESTING
//   1 reset, start, bytes 02 00 0F 00 5F E0 0F 10 4F E0 -> writes wa=0 wd=e05f000f,
//     wa=4 wd=e04f100f; done=1, cpu_reset=0 one cycle after 2nd mem_we.
//   2 len=0 (00 00) -> DONE directly, no mem_we pulse, done=1.
//   3 len=DEPTH+1 (41 00, DEPTH=64) -> err=1, cpu_reset=1, rx_ready=0, no writes;
//     then start + valid 1-word image -> err cleared, load succeeds.
//   4 random rx_valid gaps (0-7 idle cycles between bytes), len=11 -> identical
//     RAM contents vs gap-free run; each mem_we exactly 1 cycle.
//   5 reset asserted after 2 bytes of word 1 -> IDLE, all outputs at reset values;
//     new start+image loads from wa=0 with no leftover bytes in mem_wd.
//   6 start pulsed during DATA -> ignored; load completes with correct count.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the image loader.
// The slave modport is the loader itself; master is the environment (UART side + RAM).
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_wa;
  logic [31:0] mem_wd;

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_wa, mem_wd
  );

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_wa, mem_wd
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: length header (2 bytes LE) then len little-endian words,
// written to consecutive word addresses; CPU held in reset until the image is complete.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  imem_loader_if.slave       bus,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               cpu_reset_o,
  output logic [2:0]         state_o
);

  // Handshake: a byte transfers on a cycle where rx_valid && rx_ready; rx_ready is a
  // registered function of state only, and rx_data must be held while rx_valid waits.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t             state_q;
  logic               rx_ready_q;
  logic               mem_we_q;
  logic [31:0]        mem_wa_q;
  logic [31:0]        mem_wd_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               cpu_reset_q;
  logic [1:0]         byte_cnt_q;
  logic [7:0]         len_lo_q;
  logic [LEN_W-1:0]   remaining_q;

  logic               accept;
  logic               start_ok;
  logic [LEN_W-1:0]   len_d;

  assign accept   = bus.rx_valid && rx_ready_q;
  assign start_ok = start_i && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  // Header is always two bytes; the high byte completes the length on the LEN1 accept.
  assign len_d    = LEN_W'({bus.rx_data, len_lo_q});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wa_q    <= '0;
      mem_wd_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_reset_q <= 1'b1;
      byte_cnt_q  <= '0;
      len_lo_q    <= '0;
      remaining_q <= '0;
    end else if (start_ok) begin
      state_q     <= LEN0;
      rx_ready_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_wa_q    <= '0;
      mem_wd_q    <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_reset_q <= 1'b1;
      byte_cnt_q  <= '0;
    end else begin
      case (state_q)
        LEN0: if (accept) begin
          len_lo_q <= bus.rx_data;
          state_q  <= LEN1;
        end
        LEN1: if (accept) begin
          if (len_d == '0) begin
            state_q     <= DONE;
            rx_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
          end else if (len_d > LEN_W'(DEPTH)) begin
            state_q    <= ERR;
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b1;
          end else begin
            state_q     <= DATA;
            remaining_q <= len_d;
          end
        end
        DATA: if (accept) begin
          mem_wd_q[8*byte_cnt_q +: 8] <= bus.rx_data;
          byte_cnt_q                  <= byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_q    <= WRITE;
            rx_ready_q <= 1'b0;
            mem_we_q   <= 1'b1;
          end
        end
        WRITE: begin
          mem_we_q    <= 1'b0;
          remaining_q <= remaining_q - LEN_W'(1);
          // The address only advances when another word follows, so it never passes the last word.
          if (remaining_q == LEN_W'(1)) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
          end else begin
            state_q    <= DATA;
            rx_ready_q <= 1'b1;
            mem_wa_q   <= mem_wa_q + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_wa   = mem_wa_q;
  assign bus.mem_wd   = mem_wd_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign cpu_reset_o  = cpu_reset_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: one task per scenario, write monitor feeding observed queues.
module tb_imem_loader;

  logic       clk;
  logic       reset;
  logic       start_i;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  logic       cpu_reset_o;
  logic [2:0] state_o;

  imem_loader_if ifc ();

  imem_loader #(.DEPTH(64), .LEN_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .bus         (ifc.slave),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .cpu_reset_o (cpu_reset_o),
    .state_o     (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_wa_q[$];
  logic [31:0] obs_wd_q[$];
  int          we_long = 0;
  logic        we_prev = 1'b0;

  // write monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (ifc.mem_we === 1'b1) begin
      obs_wa_q.push_back(ifc.mem_wa);
      obs_wd_q.push_back(ifc.mem_wd);
      if (we_prev) we_long++;
    end
    we_prev = (ifc.mem_we === 1'b1);
  end

  // driver tasks (all entered and left at a negedge)
  task automatic do_reset();
    reset = 1'b1; start_i = 1'b0; ifc.rx_valid = 1'b0; ifc.rx_data = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) @(negedge clk);
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = b;
    for (int i = 0; i < 64; i++) begin
      if (ifc.rx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: byte %h not accepted, rx_ready=%b want 1 within 64 cycles", b, ifc.rx_ready);
    end
    @(negedge clk);
    ifc.rx_valid = 1'b0;
  endtask

  task automatic clear_obs();
    obs_wa_q.delete();
    obs_wd_q.delete();
    we_long = 0;
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({ifc.rx_ready, ifc.mem_we, busy_o, done_o, err_o, cpu_reset_o} !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_flags: rdy/we/busy/done/err/cpurst=%b want 000001",
               {ifc.rx_ready, ifc.mem_we, busy_o, done_o, err_o, cpu_reset_o});
    end
    n_cmp++;
    if ({ifc.mem_wa, ifc.mem_wd} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_wa_wd: wa=%h wd=%h want 0 0", ifc.mem_wa, ifc.mem_wd);
    end
    n_cmp++;
    if (state_o !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want 0", state_o);
    end
  endtask

  task automatic test_basic();
    do_reset();
    clear_obs();
    // byte offered in the same cycle as start must not be taken in IDLE
    start_i = 1'b1; ifc.rx_valid = 1'b1; ifc.rx_data = 8'h02;
    @(negedge clk);
    start_i = 1'b0; ifc.rx_valid = 1'b0;
    n_cmp++;
    if ({busy_o, cpu_reset_o, ifc.rx_ready, state_o} !== {3'b111, 3'd1}) begin
      n_fail++;
      $display("FAIL basic_start: busy/cpurst/rdy=%b%b%b state=%0d want 111 1",
               busy_o, cpu_reset_o, ifc.rx_ready, state_o);
    end
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h0F, 0); send_byte(8'h00, 0); send_byte(8'h5F, 0); send_byte(8'hE0, 0);
    send_byte(8'h0F, 0); send_byte(8'h10, 0); send_byte(8'h4F, 0); send_byte(8'hE0, 0);
    n_cmp++;
    if ({ifc.mem_we, done_o, cpu_reset_o} !== 3'b101) begin
      n_fail++;
      $display("FAIL basic_last_write: we/done/cpurst=%b want 101", {ifc.mem_we, done_o, cpu_reset_o});
    end
    @(negedge clk);
    n_cmp++;
    if ({ifc.mem_we, done_o, cpu_reset_o, busy_o} !== 4'b0100) begin
      n_fail++;
      $display("FAIL basic_done: we/done/cpurst/busy=%b want 0100",
               {ifc.mem_we, done_o, cpu_reset_o, busy_o});
    end
    n_cmp++;
    if (obs_wa_q.size() != 2) begin
      n_fail++;
      $display("FAIL basic_count: got %0d writes want 2", obs_wa_q.size());
    end else begin
      n_cmp++;
      if ({obs_wa_q[0], obs_wd_q[0], obs_wa_q[1], obs_wd_q[1]} !==
          {32'h0, 32'he05f000f, 32'h4, 32'he04f100f}) begin
        n_fail++;
        $display("FAIL basic_words: got %h:%h %h:%h want 0:e05f000f 4:e04f100f",
                 obs_wa_q[0], obs_wd_q[0], obs_wa_q[1], obs_wd_q[1]);
      end
    end
    n_cmp++;
    if (we_long != 0) begin
      n_fail++;
      $display("FAIL basic_we_width: %0d extended pulses want 0", we_long);
    end
  endtask

  task automatic test_len_zero();
    bit rdy_seen;
    clear_obs();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    n_cmp++;
    if ({done_o, cpu_reset_o, busy_o, err_o, state_o} !== {4'b1000, 3'd5}) begin
      n_fail++;
      $display("FAIL len0_done: done/cpurst/busy/err=%b state=%0d want 1000 5",
               {done_o, cpu_reset_o, busy_o, err_o}, state_o);
    end
    // bytes offered in DONE are back-pressured
    rdy_seen = 1'b0;
    ifc.rx_valid = 1'b1; ifc.rx_data = 8'hAA;
    repeat (4) begin
      @(negedge clk);
      if (ifc.rx_ready !== 1'b0) rdy_seen = 1'b1;
    end
    ifc.rx_valid = 1'b0;
    n_cmp++;
    if (rdy_seen || state_o !== 3'd5) begin
      n_fail++;
      $display("FAIL len0_backpressure: rdy_seen=%b state=%0d want 0 5", rdy_seen, state_o);
    end
    n_cmp++;
    if (obs_wa_q.size() != 0) begin
      n_fail++;
      $display("FAIL len0_writes: got %0d want 0", obs_wa_q.size());
    end
  endtask

  task automatic test_err();
    clear_obs();
    pulse_start();
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_done_clear: got %b want 0", done_o);
    end
    send_byte(8'h41, 0); send_byte(8'h00, 0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({err_o, cpu_reset_o, ifc.rx_ready, busy_o, done_o, state_o} !== {5'b11000, 3'd6}) begin
      n_fail++;
      $display("FAIL err_flags: err/cpurst/rdy/busy/done=%b state=%0d want 11000 6",
               {err_o, cpu_reset_o, ifc.rx_ready, busy_o, done_o}, state_o);
    end
    pulse_start();
    n_cmp++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b want 0", err_o);
    end
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    @(negedge clk);
    n_cmp++;
    if (obs_wa_q.size() != 1 || obs_wa_q[0] !== 32'h0 || obs_wd_q[0] !== 32'h12345678) begin
      n_fail++;
      $display("FAIL err_recover_write: n=%0d wa=%h wd=%h want 1 0 12345678",
               obs_wa_q.size(), obs_wa_q.size() > 0 ? obs_wa_q[0] : 32'hx,
               obs_wd_q.size() > 0 ? obs_wd_q[0] : 32'hx);
    end
    n_cmp++;
    if ({done_o, err_o, cpu_reset_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL err_recover_done: done/err/cpurst=%b want 100", {done_o, err_o, cpu_reset_o});
    end
  endtask

  task automatic run_image11(input int gap_max);
    logic [7:0] b;
    clear_obs();
    pulse_start();
    send_byte(8'h0B, $urandom_range(0, gap_max));
    send_byte(8'h00, $urandom_range(0, gap_max));
    for (int i = 0; i < 44; i++) begin
      b = 8'(i * 7 + 3);
      send_byte(b, $urandom_range(0, gap_max));
    end
    @(negedge clk);
  endtask

  task automatic test_gaps();
    logic [7:0] b0, b1, b2, b3;
    exp_q.delete();
    for (int k = 0; k < 11; k++) begin
      b0 = 8'(4 * k * 7 + 3);
      b1 = 8'((4 * k + 1) * 7 + 3);
      b2 = 8'((4 * k + 2) * 7 + 3);
      b3 = 8'((4 * k + 3) * 7 + 3);
      exp_q.push_back({b3, b2, b1, b0});
    end
    for (int run = 0; run < 2; run++) begin
      run_image11(run == 0 ? 0 : 7);
      n_cmp++;
      if (obs_wd_q.size() != 11 || done_o !== 1'b1) begin
        n_fail++;
        $display("FAIL gaps_count run%0d: writes=%0d done=%b want 11 1", run, obs_wd_q.size(), done_o);
      end else begin
        for (int k = 0; k < 11; k++) begin
          n_cmp++;
          if (obs_wa_q[k] !== 32'(4 * k) || obs_wd_q[k] !== exp_q[k]) begin
            n_fail++;
            $display("FAIL gaps_word run%0d[%0d]: got %h:%h want %h:%h",
                     run, k, obs_wa_q[k], obs_wd_q[k], 32'(4 * k), exp_q[k]);
          end
        end
      end
      n_cmp++;
      if (we_long != 0) begin
        n_fail++;
        $display("FAIL gaps_we_width run%0d: %0d extended pulses want 0", run, we_long);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    do_reset();
    n_cmp++;
    if ({ifc.rx_ready, ifc.mem_we, busy_o, done_o, err_o, cpu_reset_o} !== 6'b000001 ||
        ifc.mem_wa !== 32'h0 || ifc.mem_wd !== 32'h0 || state_o !== 3'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: flags=%b wa=%h wd=%h state=%0d want 000001 0 0 0",
               {ifc.rx_ready, ifc.mem_we, busy_o, done_o, err_o, cpu_reset_o},
               ifc.mem_wa, ifc.mem_wd, state_o);
    end
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    @(negedge clk);
    n_cmp++;
    if (obs_wa_q.size() != 1 || obs_wa_q[0] !== 32'h0 || obs_wd_q[0] !== 32'h44332211 || done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_reload: n=%0d wa=%h wd=%h done=%b want 1 0 44332211 1",
               obs_wa_q.size(), obs_wa_q.size() > 0 ? obs_wa_q[0] : 32'hx,
               obs_wd_q.size() > 0 ? obs_wd_q[0] : 32'hx, done_o);
    end
  endtask

  task automatic test_start_busy();
    clear_obs();
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    pulse_start();
    n_cmp++;
    if (state_o !== 3'd3 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL startbusy_state: state=%0d busy=%b want 3 1", state_o, busy_o);
    end
    send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'hA5, 0); send_byte(8'h5A, 0); send_byte(8'hC3, 0); send_byte(8'h3C, 0);
    @(negedge clk);
    n_cmp++;
    if (obs_wd_q.size() != 2 || done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL startbusy_count: writes=%0d done=%b want 2 1", obs_wd_q.size(), done_o);
    end else begin
      n_cmp++;
      if ({obs_wa_q[0], obs_wd_q[0], obs_wa_q[1], obs_wd_q[1]} !==
          {32'h0, 32'h04030201, 32'h4, 32'h3cc35aa5}) begin
        n_fail++;
        $display("FAIL startbusy_words: got %h:%h %h:%h want 0:04030201 4:3cc35aa5",
                 obs_wa_q[0], obs_wd_q[0], obs_wa_q[1], obs_wd_q[1]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start_i = 1'b0; ifc.rx_valid = 1'b0; ifc.rx_data = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_len_zero();
    test_err();
    test_gaps();
    test_reset_mid();
    test_start_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
